// File: rtl/sti_sched.sv
// sti_sched: round-robin command scheduler between two requesters and a serializer
module sti_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        b_req,
  input  logic [21:0] a_cmd,
  input  logic [21:0] b_cmd,
  input  logic        so_valid,
  input  logic        pixel_finish,
  output logic        a_ack,
  output logic        b_ack,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        grant_b,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_END, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [21:0] hold_q, hold_d;
  logic [9:0]  timer_q, timer_d, timer_inc;
  logic        prio_b_q, prio_b_d, grant_b_q, grant_b_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, load_q, load_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        pick_b;
  // next-state, arbitration and registered-output decode
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    prio_b_d  = prio_b_q;
    grant_b_d = grant_b_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    load_d    = 1'b0;
    pick_b    = b_req && (!a_req || prio_b_q);
    timer_inc = (timer_q == 10'd1023) ? timer_q : timer_q + 10'd1;
    case (state_q)
      IDLE: if (a_req || b_req) begin
        hold_d    = pick_b ? b_cmd : a_cmd;
        a_ack_d   = !pick_b;
        b_ack_d   = pick_b;
        grant_b_d = pick_b;
        prio_b_d  = !pick_b;
        state_d   = ISSUE;
      end
      ISSUE: if (!so_valid) begin
        load_d  = 1'b1;
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: if (so_valid) begin
        timer_d = '0;
        state_d = WAIT_END;
      end else begin
        timer_d = timer_inc;
        state_d = (timer_inc == 10'd8) ? ERR : WAIT_START;
      end
      WAIT_END: if (hold_q[0] ? pixel_finish : !so_valid) begin
        state_d = hold_q[0] ? DONE : IDLE;
      end else begin
        timer_d = timer_inc;
        state_d = (timer_inc == 10'd1023) ? ERR : WAIT_END;
      end
      default: ;
    endcase
    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = state_d == DONE;
    err_d  = state_d == ERR;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      timer_q   <= '0;
      prio_b_q  <= 1'b0;
      grant_b_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      timer_q   <= timer_d;
      prio_b_q  <= prio_b_d;
      grant_b_q <= grant_b_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} = hold_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign load    = load_q;
  assign busy    = busy_q;
  assign grant_b = grant_b_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule
